// File: rtl/work_scheduler_if.sv
// rtl/work_scheduler_if.sv - handshake bundle between work_scheduler, the host link and the hashing cores
//
// Purpose: groups the host-side work/result signals and the per-core control
// and result handshakes so the scheduler and its neighbours share one port.
// Ports (signals):
//   new_work, work_data       host -> scheduler: work block pulse and 640-bit block
//   core_header               scheduler -> cores: latched header bytes 0..75
//   core_start, core_abort    scheduler -> cores: start / abort pulses
//   core_base                 scheduler -> cores: per-core start nonce
//   core_found, core_nonce    cores -> scheduler: found level and nonce
//   core_ack                  scheduler -> cores: one-hot grant
//   core_done                 cores -> scheduler: range exhausted pulse
//   new_result, result_data   scheduler -> host: result pulse and nonce
//   busy, exhausted           scheduler status
// Modports: master = scheduler view, slave = host/core view.

interface work_scheduler_if #(
  parameter int NUM_CORES = 4
);
  logic                      new_work;
  logic [639:0]              work_data;
  logic [607:0]              core_header;
  logic                      core_start;
  logic                      core_abort;
  logic [NUM_CORES*32-1:0]   core_base;
  logic [NUM_CORES-1:0]      core_found;
  logic [NUM_CORES*32-1:0]   core_nonce;
  logic [NUM_CORES-1:0]      core_ack;
  logic [NUM_CORES-1:0]      core_done;
  logic                      new_result;
  logic [31:0]               result_data;
  logic                      busy;
  logic                      exhausted;

  modport master (
    input  new_work, work_data, core_found, core_nonce, core_done,
    output core_header, core_start, core_abort, core_base, core_ack,
           new_result, result_data, busy, exhausted
  );

  modport slave (
    output new_work, work_data, core_found, core_nonce, core_done,
    input  core_header, core_start, core_abort, core_base, core_ack,
           new_result, result_data, busy, exhausted
  );
endinterface

// File: rtl/work_scheduler.sv
// rtl/work_scheduler.sv - distributes work to hashing cores and funnels found nonces to the host
//
// Purpose: latches the work header, starts NUM_CORES cores on equal slices of
// the nonce space, round-robin arbitrates their found handshakes into a small
// FIFO and drains it as new_result pulses spaced at least RESULT_GAP cycles.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  work_scheduler_if.master (host work/result signals, core handshakes)
// FIFO_DEPTH must be a power of two, at least 2.

module work_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int RESULT_GAP = 32768
) (
  input logic              clk,
  input logic              rst,
  work_scheduler_if.master bus
);
  localparam int RRW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int PW         = AW + 1;
  localparam int BASE_SHIFT = 32 - $clog2(NUM_CORES);
  localparam logic [NUM_CORES-1:0] ALL_DONE = '1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                 state, state_nxt;
  logic [607:0]           header;
  logic [NUM_CORES-1:0]   done_mask;
  logic [RRW-1:0]         rr;
  logic [31:0]            fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [15:0]            gap_cnt;
  logic                   fifo_full, fifo_empty, abort, pop;
  logic                   grant_any;
  logic [RRW-1:0]         grant_idx, cand;
  logic [NUM_CORES-1:0]   grant_oh;
  logic [31:0]            push_data;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = ((wr_ptr - rd_ptr) == PW'(FIFO_DEPTH));
  assign abort      = (state == RUN) && bus.new_work;
  assign pop        = !fifo_empty && (gap_cnt == 16'd0);

  // Each core owns an equal, contiguous slice of the nonce space; a shift of
  // 32 (single core) yields base 0.
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_base
    assign bus.core_base[32*i +: 32] = 32'(i) << BASE_SHIFT;
  end

  // Round-robin search starting just above the last granted core. Grants are
  // withheld while the FIFO is full so requesting cores simply keep waiting.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    grant_oh  = '0;
    push_data = '0;
    if ((state == RUN) && !bus.new_work && !fifo_full) begin
      for (int k = 1; k <= NUM_CORES; k++) begin
        cand = RRW'((int'(rr) + k) % NUM_CORES);
        if (!grant_any && bus.core_found[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_any) grant_oh[grant_idx] = 1'b1;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant_oh[i]) push_data = bus.core_nonce[32*i +: 32];
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.core_start = 1'b0;
    bus.core_abort = 1'b0;
    bus.busy       = 1'b0;
    bus.exhausted  = 1'b0;
    case (state)
      IDLE: if (bus.new_work) state_nxt = LOAD;
      LOAD: begin
        bus.busy       = 1'b1;
        bus.core_start = 1'b1;
        state_nxt      = bus.new_work ? LOAD : RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        // A fresh block overrides completion detection in the same cycle.
        if (bus.new_work) begin
          bus.core_abort = 1'b1;
          state_nxt      = LOAD;
        end else if (done_mask == ALL_DONE) begin
          bus.exhausted = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      header    <= '0;
      done_mask <= '0;
      rr        <= RRW'(NUM_CORES - 1);
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      gap_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (bus.new_work) header <= bus.work_data[607:0];
      if (state == LOAD) done_mask <= '0;
      else if (state == RUN) done_mask <= done_mask | bus.core_done;
      if (grant_any) rr <= grant_idx;
      // Abort discards queued results of the old work; the gap timer keeps
      // running so the host's result copy stays protected.
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (grant_any) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop) gap_cnt <= 16'(RESULT_GAP - 1);
      else if (gap_cnt != 16'd0) gap_cnt <= gap_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (grant_any) fifo_mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign bus.core_header = header;
  assign bus.core_ack    = grant_oh;
  assign bus.new_result  = pop;
  assign bus.result_data = pop ? fifo_mem[rd_ptr[AW-1:0]] : 32'd0;
endmodule

// File: tb/tb_work_scheduler.sv
// tb/tb_work_scheduler.sv - scoreboard bench for work_scheduler with randomized core traffic

module tb_work_scheduler;
  localparam int NC  = 4;
  localparam int FD  = 8;
  localparam int GAP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc_no = 0;

  work_scheduler_if #(.NUM_CORES(NC)) bus ();

  work_scheduler #(.NUM_CORES(NC), .FIFO_DEPTH(FD), .RESULT_GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  // Nonces each behavioural core will report, in order.
  logic [31:0] pend [NC][$];
  // Expected result stream, filled by the reference model, drained by the monitor.
  logic [31:0] exp_q [$];
  int          res_t [$];

  // Reference model state (abstract: 0 idle, 1 loading, 2 running).
  int               m_st, m_rr, m_count, m_gap;
  logic [NC-1:0]    m_mask;
  logic [607:0]     m_hdr;

  task automatic chk(input string nm, input logic [607:0] act, input logic [607:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [639:0] rand_block();
    logic [639:0] d;
    for (int w = 0; w < 20; w++) d[32*w +: 32] = $urandom;
    return d;
  endfunction

  function automatic bit pend_empty();
    for (int i = 0; i < NC; i++) if (pend[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic at_mid();
    @(posedge clk); #3;
  endtask

  task automatic work_pulse(input logic [639:0] d);
    @(posedge clk); #1;
    bus.new_work = 1'b1;
    bus.work_data = d;
    @(posedge clk); #1;
    bus.new_work = 1'b0;
  endtask

  task automatic done_pulse(input logic [NC-1:0] m);
    @(posedge clk); #1;
    bus.core_done = m;
    @(posedge clk); #1;
    bus.core_done = '0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (!(m_count == 0 && pend_empty() && bus.core_found == '0) && n < bound) begin
      cyc(1);
      n++;
    end
    if (n >= bound) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d queued expected 0", m_count);
    end
  endtask

  // Behavioural cores: raise found with the next pending nonce, drop it the
  // cycle after an ack, and forget everything on abort or reset.
  initial begin : cores
    logic [NC-1:0] s_ack;
    logic          s_abort;
    bus.core_found = '0;
    bus.core_nonce = '0;
    forever begin
      @(negedge clk);
      s_ack = bus.core_ack;
      s_abort = bus.core_abort;
      @(posedge clk); #1;
      if (rst || s_abort) begin
        bus.core_found = '0;
        for (int i = 0; i < NC; i++) pend[i].delete();
      end else begin
        for (int i = 0; i < NC; i++) begin
          if (bus.core_found[i] && s_ack[i]) bus.core_found[i] = 1'b0;
          else if (!bus.core_found[i] && pend[i].size() > 0) begin
            bus.core_nonce[32*i +: 32] = pend[i].pop_front();
            bus.core_found[i] = 1'b1;
          end
        end
      end
    end
  end

  // Reference model: checks control outputs every cycle and queues expected results.
  initial begin : model
    logic              s_rst, s_nw;
    logic [639:0]      s_wd;
    logic [NC-1:0]     s_fnd, s_dn, a_ack, e_ack;
    logic [NC*32-1:0]  s_nonce;
    logic              a_start, a_abort, a_busy, a_exh, a_nr;
    logic [607:0]      a_hdr;
    logic              e_start, e_abort, e_busy, e_exh, e_pop;
    int                g, c;
    forever begin
      @(negedge clk);
      s_rst = rst; s_nw = bus.new_work; s_wd = bus.work_data;
      s_fnd = bus.core_found; s_dn = bus.core_done; s_nonce = bus.core_nonce;
      a_ack = bus.core_ack; a_start = bus.core_start; a_abort = bus.core_abort;
      a_busy = bus.busy; a_exh = bus.exhausted; a_nr = bus.new_result; a_hdr = bus.core_header;
      #1;
      if (s_rst) begin
        m_st = 0; m_rr = NC - 1; m_count = 0; m_gap = 0; m_mask = '0; m_hdr = '0;
        exp_q.delete();
      end else begin
        e_busy  = (m_st != 0);
        e_start = (m_st == 1);
        e_abort = (m_st == 2) && s_nw;
        e_exh   = (m_st == 2) && !s_nw && (&m_mask);
        g = -1;
        if (m_st == 2 && !s_nw && m_count < FD) begin
          for (int k = 1; k <= NC; k++) begin
            c = (m_rr + k) % NC;
            if (g < 0 && s_fnd[c]) g = c;
          end
        end
        e_ack = (g >= 0) ? NC'(1 << g) : '0;
        e_pop = (m_count > 0) && (m_gap == 0);

        chk("busy", a_busy, e_busy);
        chk("core_header", a_hdr, m_hdr);
        if (a_ack != '0 || e_ack != '0) chk("core_ack", a_ack, e_ack);
        if (a_start || e_start) chk("core_start", a_start, e_start);
        if (a_abort || e_abort) chk("core_abort", a_abort, e_abort);
        if (a_exh || e_exh) chk("exhausted", a_exh, e_exh);
        if (a_nr || e_pop) chk("new_result", a_nr, e_pop);

        if (e_pop) begin m_count--; m_gap = GAP - 1; end
        else if (m_gap > 0) m_gap--;
        if (g >= 0) begin
          m_count++;
          exp_q.push_back(s_nonce[32*g +: 32]);
          m_rr = g;
        end
        if (e_abort) begin m_count = 0; exp_q.delete(); end
        if (s_nw) m_hdr = s_wd[607:0];
        case (m_st)
          0: if (s_nw) m_st = 1;
          1: begin m_mask = '0; m_st = s_nw ? 1 : 2; end
          default: begin
            if (s_nw) m_st = 1;
            else if (&m_mask) m_st = 0;
            else m_mask = m_mask | s_dn;
          end
        endcase
      end
    end
  end

  // Result monitor: every new_result must match the oldest expected nonce.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.new_result) begin
        res_t.push_back(cyc_no);
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL result_unexpected: got %0h expected none", bus.result_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.result_data !== e) begin
            miscompares++;
            $display("FAIL result_data: got %0h expected %0h", bus.result_data, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    miscompares++;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : main
    logic [639:0] wd;
    int r;
    bus.new_work = 1'b0;
    bus.work_data = '0;
    bus.core_done = '0;
    #3;
    chk("rst_new_result", bus.new_result, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_core_start", bus.core_start, 1'b0);
    chk("rst_core_header", bus.core_header, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("core_base", bus.core_base, 128'hC0000000_80000000_40000000_00000000);

    // Header latch and start pulse.
    wd = rand_block();
    wd[7:0] = 8'hAA;
    work_pulse(wd);
    #1;
    chk("header_byte0", bus.core_header[7:0], 8'hAA);
    chk("start_after_work", bus.core_start, 1'b1);
    chk("busy_load", bus.busy, 1'b1);
    cyc(1);

    // Two simultaneous requesters with rr=3: core1 first, then core3.
    res_t.delete();
    at_mid();
    pend[1].push_back(32'h11111111);
    pend[3].push_back(32'h33333333);
    wait_drain(200);
    cyc(2);
    chk("two_results", res_t.size(), 2);
    if (res_t.size() == 2) chk("result_spacing", res_t[1] - res_t[0], GAP);

    // Ten founds against an eight-deep FIFO: back-pressure, nothing lost.
    res_t.delete();
    at_mid();
    for (int k = 0; k < 10; k++) pend[k % NC].push_back($urandom);
    wait_drain(400);
    cyc(2);
    chk("ten_results", res_t.size(), 10);

    // Abort with two queued entries while core2 requests.
    cyc(GAP);
    at_mid();
    pend[0].push_back($urandom);
    pend[1].push_back($urandom);
    pend[3].push_back($urandom);
    repeat (3) @(posedge clk);
    #3;
    pend[2].push_back(32'h22222222);
    wd = rand_block();
    @(posedge clk); #1;
    bus.new_work = 1'b1;
    bus.work_data = wd;
    #1;
    chk("abort_pulse", bus.core_abort, 1'b1);
    chk("abort_no_ack", bus.core_ack, '0);
    @(posedge clk); #1;
    bus.new_work = 1'b0;
    #1;
    chk("start_after_abort", bus.core_start, 1'b1);
    cyc(2 * GAP);

    // Completion: done pulses on different cycles, results drain in IDLE.
    at_mid();
    pend[0].push_back($urandom);
    pend[1].push_back($urandom);
    cyc(4);
    done_pulse(4'b0001);
    cyc(2);
    done_pulse(4'b0100);
    done_pulse(4'b0010);
    cyc(3);
    done_pulse(4'b1000);
    cyc(2);
    chk("idle_busy", bus.busy, 1'b0);
    // Requests and done pulses outside RUN must be ignored.
    at_mid();
    pend[1].push_back($urandom);
    done_pulse(4'b1111);
    cyc(5);
    work_pulse(rand_block());
    wait_drain(200);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      at_mid();
      r = $urandom_range(0, 199);
      if (r < 30) pend[$urandom_range(0, NC - 1)].push_back($urandom);
      @(posedge clk); #1;
      if (r == 199) bus.new_work = 1'b1;
      bus.work_data = rand_block();
      if (r >= 190 && r < 196) bus.core_done = 4'($urandom);
      @(posedge clk); #1;
      bus.new_work = 1'b0;
      bus.core_done = '0;
    end
    wait_drain(400);
    cyc(GAP + 2);
    chk("scoreboard_empty", exp_q.size(), 0);

    // Asynchronous reset while running with three queued results.
    work_pulse(rand_block());
    cyc(GAP);
    at_mid();
    for (int i = 0; i < NC; i++) pend[i].push_back($urandom);
    r = 0;
    while (m_count != 3 && r < 40) begin at_mid(); r++; end
    chk("three_queued", m_count, 3);
    at_mid();
    rst = 1'b1;
    #1;
    chk("arst_new_result", bus.new_result, 1'b0);
    chk("arst_result_data", bus.result_data, 32'd0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_ack", bus.core_ack, '0);
    chk("arst_header", bus.core_header, '0);
    chk("arst_exhausted", bus.exhausted, 1'b0);
    cyc(2);
    rst = 1'b0;
    res_t.delete();
    cyc(40);
    chk("post_rst_busy", bus.busy, 1'b0);
    chk("post_rst_no_result", res_t.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/work_scheduler.md
Name: work_scheduler

Overview:
Sits between serial_handler and the array of hashing cores. It latches the 640-bit work block on new_work, splits the 32-bit nonce space evenly across NUM_CORES cores, and starts them. It round-robin arbitrates their found-nonce handshakes into a small result FIFO. FIFO entries drain to serial_handler as single-cycle new_result pulses, spaced far enough apart that its one-deep result copy is never overwritten.

Parameters:
NUM_CORES, 4, number of hashing cores; power of two, 1..16.
FIFO_DEPTH, 8, result FIFO entries; power of two.
RESULT_GAP, 32768, minimum clk cycles between successive new_result pulses; ≥1, ≤65535.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
new_work  in  1  single-cycle pulse from serial_handler
work_data  in  640  80-byte block header; byte n at bits [8n+7:8n]
core_header  out  608  latched header bytes 0..75
core_start  out  1  single-cycle pulse: cores load base and begin
core_abort  out  1  single-cycle pulse: cores stop and clear found/done
core_base  out  NUM_CORES*32  start nonce per core; slice i = [32i+31:32i]
core_found  in  NUM_CORES  level; core holds found and nonce until acked
core_nonce  in  NUM_CORES*32  found nonce per core
core_ack  out  NUM_CORES  one-hot single-cycle grant
core_done  in  NUM_CORES  pulse: core exhausted its range
new_result  out  1  single-cycle pulse to serial_handler
result_data  out  32  nonce, valid while new_result=1
busy  out  1  high in LOAD or RUN
exhausted  out  1  pulse: every core finished the current work

Behaviour:
- Reset values (async, any state): state=IDLE; all outputs 0; core_header=0; FIFO empty; gap counter=0; rr pointer=NUM_CORES-1; done mask=0.
- core_base[i] = i << (32 - log2(NUM_CORES)). This is constant; with NUM_CORES=1, base=0.
- State IDLE:
  - busy=0.
  - On new_work: latch work_data[607:0] into core_header, then go to LOAD.
- State LOAD (exactly one cycle unless extended):
  - core_start=1, done mask cleared, then go to RUN.
  - new_work in LOAD: re-latch header and stay in LOAD one more cycle; core_start still pulses each LOAD cycle.
- State RUN:
  - Each core_done[i] pulse sets done mask bit i.
  - When the mask is all ones: pulse exhausted for 1 cycle and go to IDLE.
  - new_work in RUN: core_abort=1 this cycle, latch new header, flush FIFO, then go to LOAD. Any grant that same cycle is suppressed.
- Arbiter (RUN only, excluding the abort cycle):
  - Request set = core_found, gated by FIFO not full.
  - Grant goes to the first requester searching from rr+1 upward, wrapping.
  - core_ack[g]=1 for one cycle; core_nonce[g] is written to the FIFO the same cycle; rr<=g.
  - At most one grant per cycle.
  - FIFO full: no ack; cores hold their request; nothing is lost.
  - A core must drop found the cycle after ack. Re-asserting after that is a new result.
- Drain:
  - Independent of state, including IDLE.
  - When FIFO not empty and gap counter==0: pop, assert new_result=1 with result_data=head for 1 cycle, load gap counter with RESULT_GAP-1.
  - Otherwise the counter decrements toward 0, saturating at 0.
  - Latency: when FIFO is empty and the counter is 0, the pulse occurs the cycle after the push.
- Simultaneous push and pop on a full FIFO: the push is not granted that cycle (the full flag is registered). Pop proceeds.
- FIFO flush (on abort) resets read and write pointers but leaves the gap counter running.
- core_done pulses outside RUN are ignored. core_found outside RUN is not acked.
- Arithmetic: FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. The gap counter is 16 bits.

Test Plan:
- Reset mid-RUN with 3 entries in FIFO: all outputs 0 immediately (async); no new_result after release; busy=0.
- NUM_CORES=4, new_work with work_data byte0=0xAA: core_header[7:0]=0xAA; core_start pulses 1 cycle later; core_base={0xC0000000,0x80000000,0x40000000,0}; busy=1.
- Cores 1 and 3 raise found together (nonces 0x11111111, 0x33333333), rr=3: ack core1 then core3 on consecutive cycles; first new_result=0x11111111; second exactly RESULT_GAP cycles later (test with RESULT_GAP=4).
- 10 founds with FIFO_DEPTH=8, RESULT_GAP=100: 8 acked; the remaining 2 held until pops free slots; all 10 nonces emitted in grant order, none lost.
- new_work during RUN with 2 FIFO entries and core2 found asserted: core_abort pulses; core2 not acked; FIFO emits nothing further; core_start pulses the next cycle.
- core_done pulses on all 4 cores across different cycles: exhausted pulses once, the cycle after the last done; state IDLE; busy=0; pending FIFO entries still drain.
